scope_trigger_capture: RTL and testbench
========================================

Name: scope_trigger_capture

Overview:
- Capture engine directly downstream of the ADC SPI reader. Consumes each 12-bit ADC word plus a one-cycle valid strobe.
- Stores samples in a circular sample RAM.
- Detects an edge trigger against a programmable level and freezes a window of DEPTH samples around it: pre_count samples before the trigger, the rest from the trigger on.
- The display/readout logic reads the frozen window by logical index.

Parameters:
- DW, 12, sample width; matches the ADC word.
- AW, 9, RAM address width; DEPTH = 2**AW = 512 samples.

Ports:
- clk  in  1  system clock.
- Reset  in  1  synchronous, active-high reset.
- sample_in  in  DW  ADC sample word; sampled only when sample_valid=1.
- sample_valid  in  1  one-cycle strobe per new ADC conversion.
- arm  in  1  pulse; starts or restarts a capture.
- force_trig  in  1  pulse; forces a trigger on the next valid sample in WAIT_TRIG.
- trig_level  in  DW  unsigned trigger threshold; latched at arm.
- trig_slope  in  1  0 = rising, 1 = falling; latched at arm.
- pre_count  in  AW  pretrigger depth; latched at arm.
- rd_index  in  AW  logical read index; 0 = oldest sample in the window.
- rd_data  out  DW  sample at rd_index; registered, 1-cycle latency.
- armed  out  1  high in PREFILL and WAIT_TRIG.
- triggered  out  1  high in POST and DONE.
- done  out  1  high in DONE.
- start_ptr  out  AW  physical RAM address of logical index 0.

Behaviour:
- Reset:
  - state=IDLE; armed, triggered, done = 0.
  - start_ptr, wr_ptr, counters, rd_data = 0.
  - prev_valid = 0; force_pending = 0.
  - RAM contents are not cleared.
- Writes occur only in PREFILL, WAIT_TRIG and POST, only on sample_valid cycles. Each write goes to RAM[wr_ptr], then wr_ptr <= wr_ptr+1 (mod DEPTH, natural wrap).
- arm in any state, including mid-capture:
  - next state PREFILL.
  - wr_ptr, fill_cnt, post_cnt <= 0; prev_valid <= 0; force_pending <= 0.
  - Latch trig_level, trig_slope and pre_count; pre_count is used as given (0..DEPTH-1).
  - If arm and sample_valid coincide, the sample is not written.
- FSM:
  - IDLE: no writes; waits for arm.
  - PREFILL: write valid samples and increment fill_cnt. When fill_cnt reaches the latched pre_count, go to WAIT_TRIG. With pre_count=0, go to WAIT_TRIG on the cycle after arm.
  - WAIT_TRIG: write valid samples; evaluate the trigger on each valid sample, cur = sample_in, prev = last valid sample.
    - Rising: prev_valid && prev < level && cur >= level.
    - Falling: prev_valid && prev > level && cur <= level.
    - The first sample after arm never edge-triggers.
    - force_trig sets force_pending; the next valid sample then triggers regardless of level.
    - On trigger: start_ptr <= wr_ptr - pre_count (mod DEPTH); post_cnt <= 1; go to POST. The trigger sample itself is written and sits at logical index pre_count.
    - force_trig outside WAIT_TRIG is ignored.
  - POST: write valid samples and increment post_cnt. Go to DONE when post_cnt reaches DEPTH - pre_count, i.e. on the cycle after the final window sample is written. Trigger conditions are ignored.
  - DONE: no writes; window frozen; waits for arm.
- Edge cases:
  - prev/prev_valid update on every valid sample in PREFILL and WAIT_TRIG. Samples written in PREFILL therefore serve as prev for the first WAIT_TRIG evaluation.
  - Comparisons are unsigned DW-bit.
- Read path:
  - Physical address = start_ptr + rd_index (mod DEPTH).
  - rd_data is valid one clk after rd_index is presented, in any state.
  - A same-cycle read and write to one address returns the old contents (read-first).
  - Reads during capture return in-progress data; only reads in DONE are guaranteed coherent.
- Reset mid-operation aborts the capture immediately; the RAM keeps stale data.
- Implementation: one inferred single-clock dual-port block RAM (one write port, one registered read port).

Test Plan:
- Reset asserted during POST -> next cycle state IDLE, armed=triggered=done=0, rd_data=0; a following valid sample is not written (confirm via arm-less readback of unchanged address).
- arm, pre_count=4, level=0x800, rising, ramp 0x000,0x100,... one valid every 16 clk:
  - Trigger on the sample 0x800; triggered rises one clk after its valid.
  - done after 508 samples from the trigger inclusive.
  - rd_index 4 -> 0x800; rd_index 3 -> 0x700; rd_index 0 -> 0x400; rd_index 5 -> 0x900 (mod-12-bit ramp).
- Same ramp, trig_slope=1 -> no trigger; armed stays 1, triggered 0. A force_trig pulse then triggers on the next valid sample, and rd_index pre_count holds that sample.
- pre_count=0, first sample after arm already >= level -> no trigger on it; trigger only on a later true crossing.
- pre_count=511 with long prefill so wr_ptr wraps -> start_ptr = trigger address - 511 mod 512; rd_index 511 = trigger sample; done after exactly 1 post sample.
- arm pulsed mid-POST -> state PREFILL, triggered=0, counters cleared; the new capture completes correctly with the new latched level.

Source files
------------

// File: rtl/scope_trigger_capture.sv
// rtl/scope_trigger_capture.sv - edge-triggered sample capture into a circular RAM with pretrigger window
module scope_trigger_capture #(
  parameter int DW = 12,
  parameter int AW = 9
) (
  input  logic          clk,
  input  logic          Reset,
  input  logic [DW-1:0] sample_in,
  input  logic          sample_valid,
  input  logic          arm,
  input  logic          force_trig,
  input  logic [DW-1:0] trig_level,
  input  logic          trig_slope,
  input  logic [AW-1:0] pre_count,
  input  logic [AW-1:0] rd_index,
  output logic [DW-1:0] rd_data,
  output logic          armed,
  output logic          triggered,
  output logic          done,
  output logic [AW-1:0] start_ptr
);

  localparam int DEPTH = 1 << AW;

  typedef enum logic [2:0] {
    S_IDLE,
    S_PREFILL,
    S_WAIT,
    S_POST,
    S_DONE
  } state_t;

  state_t        state, state_nxt;
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_addr;
  logic [AW:0]   fill_cnt;
  logic [AW:0]   post_cnt;
  logic [AW:0]   pre_ext;
  logic [AW:0]   post_limit;
  logic [DW-1:0] lvl_q;
  logic [DW-1:0] prev_q;
  logic [AW-1:0] pre_q;
  logic          slope_q;
  logic          prev_valid;
  logic          force_pending;
  logic          wr_en;
  logic          track;
  logic          trig_hit;
  logic          edge_hit;

  logic [DW-1:0] mem [DEPTH];

  assign pre_ext    = {1'b0, pre_q};
  assign post_limit = (AW+1)'(DEPTH) - pre_ext;
  assign rd_addr    = start_ptr + rd_index;

  assign armed     = (state == S_PREFILL) || (state == S_WAIT);
  assign triggered = (state == S_POST) || (state == S_DONE);
  assign done      = (state == S_DONE);

  always_comb begin
    edge_hit = 1'b0;
    if (prev_valid) begin
      if (slope_q)
        edge_hit = (prev_q > lvl_q) && (sample_in <= lvl_q);
      else
        edge_hit = (prev_q < lvl_q) && (sample_in >= lvl_q);
    end
  end

  always_ff @(posedge clk) begin
    if (Reset)
      state <= S_IDLE;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    wr_en     = 1'b0;
    track     = 1'b0;
    trig_hit  = 1'b0;
    if (arm) begin
      state_nxt = S_PREFILL;
    end else begin
      case (state)
        S_PREFILL: begin
          if (sample_valid) begin
            wr_en = 1'b1;
            track = 1'b1;
          end
          if ((fill_cnt == pre_ext) ||
              (sample_valid && (fill_cnt + (AW+1)'(1) == pre_ext)))
            state_nxt = S_WAIT;
        end
        S_WAIT: begin
          if (sample_valid) begin
            wr_en = 1'b1;
            track = 1'b1;
            if (force_pending || edge_hit) begin
              trig_hit  = 1'b1;
              state_nxt = S_POST;
            end
          end
        end
        S_POST: begin
          // a full pretrigger window leaves no room for post samples beyond the trigger
          if (post_cnt == post_limit) begin
            state_nxt = S_DONE;
          end else if (sample_valid) begin
            wr_en = 1'b1;
            if (post_cnt + (AW+1)'(1) == post_limit)
              state_nxt = S_DONE;
          end
        end
        S_IDLE, S_DONE: state_nxt = state;
        default:        state_nxt = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (Reset) begin
      wr_ptr        <= '0;
      fill_cnt      <= '0;
      post_cnt      <= '0;
      start_ptr     <= '0;
      lvl_q         <= '0;
      slope_q       <= 1'b0;
      pre_q         <= '0;
      prev_q        <= '0;
      prev_valid    <= 1'b0;
      force_pending <= 1'b0;
    end else if (arm) begin
      wr_ptr        <= '0;
      fill_cnt      <= '0;
      post_cnt      <= '0;
      lvl_q         <= trig_level;
      slope_q       <= trig_slope;
      pre_q         <= pre_count;
      prev_valid    <= 1'b0;
      force_pending <= 1'b0;
    end else begin
      if (wr_en)
        wr_ptr <= wr_ptr + AW'(1);
      if (wr_en && (state == S_PREFILL))
        fill_cnt <= fill_cnt + (AW+1)'(1);
      if (track) begin
        prev_q     <= sample_in;
        prev_valid <= 1'b1;
      end
      if (trig_hit) begin
        start_ptr     <= wr_ptr - pre_q;
        post_cnt      <= (AW+1)'(1);
        force_pending <= 1'b0;
      end else begin
        if (wr_en && (state == S_POST))
          post_cnt <= post_cnt + (AW+1)'(1);
        if (force_trig && (state == S_WAIT))
          force_pending <= 1'b1;
      end
    end
  end

  // read-first dual-port RAM; contents survive reset
  always_ff @(posedge clk) begin
    if (wr_en && !Reset)
      mem[wr_ptr] <= sample_in;
  end

  always_ff @(posedge clk) begin
    if (Reset)
      rd_data <= '0;
    else
      rd_data <= mem[rd_addr];
  end

endmodule

// File: tb/tb_scope_trigger_capture.sv
// tb/tb_scope_trigger_capture.sv - randomized and directed bench against a sample-history window model
module tb_scope_trigger_capture;

  localparam int DW    = 12;
  localparam int AW    = 9;
  localparam int DEPTH = 512;

  logic          clk = 1'b0;
  logic          Reset;
  logic [DW-1:0] sample_in;
  logic          sample_valid;
  logic          arm;
  logic          force_trig;
  logic [DW-1:0] trig_level;
  logic          trig_slope;
  logic [AW-1:0] pre_count;
  logic [AW-1:0] rd_index;
  logic [DW-1:0] rd_data;
  logic          armed;
  logic          triggered;
  logic          done;
  logic [AW-1:0] start_ptr;

  always #5 clk = ~clk;

  scope_trigger_capture #(.DW(DW), .AW(AW)) dut (
    .clk          (clk),
    .Reset        (Reset),
    .sample_in    (sample_in),
    .sample_valid (sample_valid),
    .arm          (arm),
    .force_trig   (force_trig),
    .trig_level   (trig_level),
    .trig_slope   (trig_slope),
    .pre_count    (pre_count),
    .rd_index     (rd_index),
    .rd_data      (rd_data),
    .armed        (armed),
    .triggered    (triggered),
    .done         (done),
    .start_ptr    (start_ptr)
  );

  int          n_checks = 0;
  int          n_errors = 0;
  logic [11:0] hist[$];
  logic [11:0] shadow[DEPTH];
  int          cur_pre;
  logic [11:0] cur_lvl;
  logic        cur_slope;
  int          force_at;

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // index in hist of the trigger sample, or -1 while no trigger has happened
  function automatic int find_trig();
    for (int k = cur_pre; k < hist.size(); k++) begin
      if (k == force_at) return k;
      if (k >= 1) begin
        if (!cur_slope && hist[k-1] < cur_lvl && hist[k] >= cur_lvl) return k;
        if (cur_slope && hist[k-1] > cur_lvl && hist[k] <= cur_lvl) return k;
      end
    end
    return -1;
  endfunction

  function automatic bit model_done();
    int t;
    t = find_trig();
    return (t >= 0) && (hist.size() >= t + DEPTH - cur_pre);
  endfunction

  function automatic logic [11:0] gen(input int mode, input int i);
    case (mode)
      0: return 12'((i * 256) % 4096);
      1: return 12'($urandom_range(0, 4095));
      2: begin
        case (i)
          0: return 12'hA00;
          1: return 12'h900;
          2: return 12'h300;
          3: return 12'h500;
          4: return 12'h900;
          default: return 12'((i * 55) % 4096);
        endcase
      end
      default: return (i < 600) ? 12'h100 : 12'hF00;
    endcase
  endfunction

  task automatic commit_shadow();
    for (int k = 0; k < hist.size(); k++) shadow[k % DEPTH] = hist[k];
  endtask

  task automatic start_cap(input int pre, input logic [11:0] lvl, input logic slope);
    cur_pre   = pre;
    cur_lvl   = lvl;
    cur_slope = slope;
    force_at  = -1;
    hist.delete();
    pre_count  = pre[AW-1:0];
    trig_level = lvl;
    trig_slope = slope;
    arm = 1'b1;
    tick(1);
    arm = 1'b0;
    chk("arm_armed", 32'(armed), 32'd1);
    chk("arm_triggered", 32'(triggered), 32'd0);
    chk("arm_done", 32'(done), 32'd0);
    tick(3);
  endtask

  task automatic send(input logic [11:0] v);
    int t;
    sample_in    = v;
    sample_valid = 1'b1;
    tick(1);
    sample_valid = 1'b0;
    hist.push_back(v);
    t = find_trig();
    chk("triggered", 32'(triggered), 32'(t >= 0));
    chk("armed", 32'(armed), 32'(t < 0));
    tick(15);
    chk("done", 32'(done), 32'(model_done()));
  endtask

  task automatic feed(input int mode, input int n, input int force_k);
    for (int i = 0; i < n && !model_done(); i++) begin
      if (hist.size() == force_k && find_trig() < 0) begin
        force_trig = 1'b1;
        tick(1);
        force_trig = 1'b0;
        tick(1);
        force_at = hist.size();
      end
      send(gen(mode, hist.size()));
    end
  endtask

  task automatic read_at(input string tag, input int idx, input logic [11:0] exp);
    rd_index = idx[AW-1:0];
    tick(1);
    chk(tag, 32'(rd_data), 32'(exp));
  endtask

  task automatic verify_window();
    int t;
    t = find_trig();
    chk("window_done", 32'(done), 32'd1);
    if (t >= 0) begin
      chk("start_ptr", 32'(start_ptr), 32'((t - cur_pre) % DEPTH));
      for (int i = 0; i < DEPTH; i++)
        read_at($sformatf("rd_data[%0d]", i), i, hist[t - cur_pre + i]);
    end
    commit_shadow();
  endtask

  initial begin
    Reset        = 1'b1;
    sample_in    = '0;
    sample_valid = 1'b0;
    arm          = 1'b0;
    force_trig   = 1'b0;
    trig_level   = '0;
    trig_slope   = 1'b0;
    pre_count    = '0;
    rd_index     = '0;
    force_at     = -1;
    cur_pre      = 0;
    cur_lvl      = '0;
    cur_slope    = 1'b0;
    tick(3);
    chk("rst_armed", 32'(armed), 32'd0);
    chk("rst_triggered", 32'(triggered), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_rd_data", 32'(rd_data), 32'd0);
    chk("rst_start_ptr", 32'(start_ptr), 32'd0);
    Reset = 1'b0;
    tick(2);

    // rising ramp, pretrigger 4
    start_cap(4, 12'h800, 1'b0);
    feed(0, 700, -1);
    verify_window();
    chk("ramp_start_ptr", 32'(start_ptr), 32'd4);
    read_at("ramp_idx4", 4, 12'h800);
    read_at("ramp_idx3", 3, 12'h700);
    read_at("ramp_idx0", 0, 12'h400);
    read_at("ramp_idx5", 5, 12'h900);

    // reset in POST aborts; a later valid sample must not be written
    start_cap(4, 12'h800, 1'b0);
    feed(0, 20, -1);
    chk("pre_reset_post", 32'(triggered), 32'd1);
    commit_shadow();
    Reset = 1'b1;
    tick(1);
    Reset = 1'b0;
    chk("abort_armed", 32'(armed), 32'd0);
    chk("abort_triggered", 32'(triggered), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    chk("abort_rd_data", 32'(rd_data), 32'd0);
    chk("abort_start_ptr", 32'(start_ptr), 32'd0);
    sample_in    = 12'hABC;
    sample_valid = 1'b1;
    tick(1);
    sample_valid = 1'b0;
    tick(2);
    chk("idle_armed", 32'(armed), 32'd0);
    read_at("idle_nowrite0", 0, shadow[0]);
    read_at("idle_nowrite1", 1, shadow[1]);

    // falling slope never sees an edge on the rising ramp; force_trig takes over
    start_cap(4, 12'h800, 1'b1);
    feed(0, 12, -1);
    chk("fall_armed", 32'(armed), 32'd1);
    chk("fall_triggered", 32'(triggered), 32'd0);
    feed(0, 700, 12);
    verify_window();
    read_at("force_idx_pre", 4, 12'hC00);

    // pretrigger 0: first sample above level must not trigger
    start_cap(0, 12'h800, 1'b0);
    feed(2, 700, -1);
    verify_window();
    read_at("pre0_idx0", 0, 12'h900);

    // pretrigger 511 with wrapped write pointer
    start_cap(511, 12'h800, 1'b0);
    feed(3, 700, -1);
    verify_window();
    chk("wrap_start_ptr", 32'(start_ptr), 32'd89);
    read_at("wrap_idx511", 511, 12'hF00);

    // re-arm mid-POST with a new level and pretrigger depth
    start_cap(4, 12'h800, 1'b0);
    feed(0, 20, -1);
    chk("mid_post_triggered", 32'(triggered), 32'd1);
    commit_shadow();
    start_cap(8, 12'h300, 1'b0);
    feed(0, 700, -1);
    verify_window();
    read_at("rearm_idx8", 8, 12'h300);

    // random captures with a forced fallback
    for (int r = 0; r < 2; r++) begin
      int pre;
      pre = $urandom_range(1, 400);
      start_cap(pre, 12'($urandom_range(0, 4095)), 1'($urandom_range(0, 1)));
      feed(1, 700, pre + 30);
      verify_window();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
